// File: rtl/riscv_defs.sv
// Shared RISC-V definitions: datapath width, reset vector default, NOP encoding.
package riscv_defs;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/riscv_fetch_fifo.sv
// Prefetch buffer: {instr, pc} entries, first-word fall-through head, synchronous flush.
module riscv_fetch_fifo
    import riscv_defs::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [2*XLEN-1:0]             push_data,
    input  logic                          pop,
    input  logic                          flush,
    output logic [2*XLEN-1:0]             head_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH+1)-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [2*XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              wr_en;
    logic              rd_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        empty     = (cnt == '0);
        full      = (cnt == CW'(DEPTH));
        count     = cnt;
        head_data = mem[rd_ptr];
        // A push into a full buffer is only legal when the head leaves the same cycle.
        wr_en     = push && (!full || pop) && !flush;
        rd_en     = pop && !empty && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            if (wr_en && !rd_en)      cnt <= cnt + CW'(1);
            else if (!wr_en && rd_en) cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch: credit-limited request issue, in-flight PC tracking,
// redirect with drop counting for stale responses, and a prefetch buffer.
module riscv_fetch
    import riscv_defs::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0]   pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_nxt;
    logic [CW-1:0]     drop;
    logic [PW-1:0]     ip_wr;
    logic [PW-1:0]     ip_rd;
    logic [XLEN-1:0]   ip_pc [FIFO_DEPTH];

    logic              req_acc;
    logic              rsp_ok;
    logic              rsp_keep;
    logic [CW:0]       credits_used;

    logic              fifo_pop;
    logic [2*XLEN-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        credits_used   = {1'b0, outstanding} + {1'b0, fifo_count};
        imem_req_valid = !rst && !redirect_valid && !fifo_full
                         && (int'(credits_used) < FIFO_DEPTH);
        req_acc        = imem_req_valid && imem_req_ready;
        // Responses with nothing outstanding are protocol violations and are ignored.
        rsp_ok         = !rst && imem_rsp_valid && (outstanding != '0);
        rsp_keep       = rsp_ok && !redirect_valid && (drop == '0);
        outstanding_nxt = outstanding;
        if (req_acc && !rsp_ok)      outstanding_nxt = outstanding + CW'(1);
        else if (!req_acc && rsp_ok) outstanding_nxt = outstanding - CW'(1);
    end

    always_comb begin
        imem_req_addr = pc;
        out_valid     = !rst && !fifo_empty;
        out_pc        = fifo_head[XLEN-1:0];
        out_instr     = fifo_empty ? NOP_INSTR : fifo_head[2*XLEN-1:XLEN];
        fifo_pop      = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            ip_wr       <= '0;
            ip_rd       <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid)   pc <= align_pc(redirect_pc);
            else if (req_acc)     pc <= pc + 32'd4;
            if (req_acc) ip_wr <= ptr_inc(ip_wr);
            if (rsp_ok)  ip_rd <= ptr_inc(ip_rd);
            // Everything still in flight after a redirect belongs to the old path.
            if (redirect_valid)            drop <= outstanding_nxt;
            else if (rsp_ok && drop != '0) drop <= drop - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (req_acc) ip_pc[ip_wr] <= pc;
    end

    riscv_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_keep),
        .push_data ({imem_rsp_data, ip_pc[ip_rd]}),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch with an in-order, fixed-latency memory model.
module tb_riscv_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    always #5 clk = ~clk;

    riscv_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          pops = 0;
    int          pcnt;
    int          n;
    logic [31:0] exp_req;
    logic [31:0] exp_pc;
    logic [31:0] last_acc;
    bit          inject;
    bit          wrap_seen;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive memory response, observe handshakes, advance to next negedge.
    task automatic tick();
        if (rst) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mq[0].addr);
            void'(mq.pop_front());
        end else if (inject) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else begin
            imem_rsp_valid = 1'b0;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req);
            if (imem_req_addr == 32'h0 && last_acc == 32'hFFFF_FFFC) wrap_seen = 1'b1;
            last_acc = imem_req_addr;
            mq.push_back('{imem_req_addr, cyc + lat});
            exp_req = exp_req + 32'd4;
        end
        if (out_valid && out_ready && !redirect_valid) begin
            chk("out_pc", out_pc, exp_pc);
            chk("out_instr", out_instr, mem_data(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        chk1("inflight_le_2", mq.size() <= 2, 1'b1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        exp_req        = 32'h0;
        exp_pc         = 32'h0;
        last_acc       = 32'h0;
        inject         = 1'b0;
        wrap_seen      = 1'b0;

        repeat (3) begin
            tick();
            chk1("rst_req_valid", imem_req_valid, 1'b0);
            chk1("rst_out_valid", out_valid, 1'b0);
        end

        rst = 1'b0;
        #1;
        chk1("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        repeat (20) tick();
        chk1("steady_pops", pops >= 10, 1'b1);

        out_ready = 1'b0;
        repeat (10) tick();
        chk1("stall_req_valid", imem_req_valid, 1'b0);
        chk1("stall_out_valid", out_valid, 1'b1);
        chk("stall_fifo_count", 32'(dut.u_fifo.count), 32'd2);
        out_ready = 1'b1;
        pcnt = pops;
        repeat (8) tick();
        chk1("stall_resume_pops", pops >= pcnt + 4, 1'b1);

        lat = 3;
        n = 0;
        while (dut.outstanding != 2 && n < 30) begin
            tick();
            n++;
        end
        chk("wait_two_outstanding", 32'(dut.outstanding), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        chk1("redirect_req_valid", imem_req_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        exp_req = 32'h0000_0100;
        exp_pc  = 32'h0000_0100;
        chk1("post_redirect_out_valid", out_valid, 1'b0);
        pcnt = pops;
        repeat (20) tick();
        chk1("redirect_progress", pops > pcnt, 1'b1);

        pcnt = pops;
        repeat (60) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            tick();
        end
        imem_req_ready = 1'b1;
        repeat (6) tick();
        chk1("random_progress", pops > pcnt + 5, 1'b1);

        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        exp_req   = 32'hFFFF_FFF8;
        exp_pc    = 32'hFFFF_FFF8;
        wrap_seen = 1'b0;
        repeat (15) tick();
        chk1("pc_wrap_seen", wrap_seen, 1'b1);

        imem_req_ready = 1'b0;
        repeat (10) tick();
        chk("idle_outstanding", 32'(dut.outstanding), 32'd0);
        chk1("idle_out_valid", out_valid, 1'b0);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk1("spurious_out_valid", out_valid, 1'b0);
        chk("spurious_outstanding", 32'(dut.outstanding), 32'd0);
        imem_req_ready = 1'b1;

        lat = 3;
        n = 0;
        while (dut.outstanding != 1 && n < 30) begin
            tick();
            n++;
        end
        chk("wait_one_outstanding", 32'(dut.outstanding), 32'd1);
        rst = 1'b1;
        tick();
        chk1("rst_mid_out_valid", out_valid, 1'b0);
        chk1("rst_mid_req_valid", imem_req_valid, 1'b0);
        rst     = 1'b0;
        exp_req = 32'h0;
        exp_pc  = 32'h0;
        lat     = 1;
        #1;
        chk("rst_mid_first_addr", imem_req_addr, 32'h0);
        pcnt = pops;
        repeat (15) tick();
        chk1("rst_mid_progress", pops > pcnt + 5, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_fetch.md
RISCV_FETCH -- requirements
Module: riscv_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the prefetch buffer entries and the maximum in-flight credits.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 SHALL have port imem_rsp_valid  input  1  returned instruction is valid.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  core requests a PC change (branch/jump/trap).
REQ-011 SHALL have port redirect_pc  input  32  new fetch target.
REQ-012 SHALL have port out_valid  output  1  instruction available to decode.
REQ-013 SHALL have port out_instr  output  32  instruction word to decode.
REQ-014 SHALL have port out_pc  output  32  address of out_instr.
REQ-015 SHALL have port out_ready  input  1  decode consumes the instruction this cycle.

Function
REQ-016 SHALL count a request as accepted when imem_req_valid && imem_req_ready.
REQ-017 SHALL assume in-order memory responses, exactly one per accepted request, at least 1 cycle after acceptance.
REQ-018 SHALL assert imem_req_valid only when outstanding + FIFO occupancy < FIFO_DEPTH and redirect_valid is low.
REQ-019 SHALL drive imem_req_addr = fetch PC; PC advances by 4 on acceptance; 32'hFFFF_FFFC wraps to 0.
REQ-020 SHALL hold a 32-bit PC per in-flight request so that each pushed entry carries its own address.
REQ-021 SHALL push {imem_rsp_data, pc} into the FIFO on imem_rsp_valid when the drop counter is zero.
REQ-022 SHALL drive out_valid = FIFO not empty, with out_instr/out_pc taken from the head entry (first-word fall-through).
REQ-023 SHALL pop the FIFO on out_valid && out_ready; a simultaneous push and pop leaves occupancy unchanged, including when full.
REQ-024 SHALL, on redirect_valid, set the PC to {redirect_pc[31:2], 2'b00}, flush the FIFO, and set drop = outstanding (including any request accepted that cycle, but excluding any response arriving that cycle).
REQ-025 SHALL discard any response arriving in the redirect cycle, or while drop > 0, decrementing drop for each such response.
REQ-026 SHALL, on imem_rsp_valid with no outstanding request (protocol violation), ignore the response and leave state unchanged.
REQ-027 SHALL give a fetch-to-out_valid latency of memory latency + 1 cycle (registered FIFO write).
REQ-028 SHALL assert out_valid no earlier than 1 cycle after a redirect, and only with post-redirect instructions.

Reset
REQ-029 SHALL, while rst is high at a clock edge, set PC = RESET_PC, FIFO empty, outstanding = 0, drop = 0.
REQ-030 SHALL hold imem_req_valid = 0 and out_valid = 0 while rst is high; out_instr and out_pc are don't-care.
REQ-031 SHALL issue its first request, at RESET_PC, in the first cycle after rst falls.
REQ-032 SHALL, on reset mid-operation, discard all in-flight responses; the memory model is reset alongside the core.

Structure
REQ-033 SHALL take the RESET_PC default, the instruction width (32) and the NOP encoding (32'h0000_0013) from the shared riscv_defs header.
REQ-034 SHALL implement the buffer as sub-module riscv_fetch_fifo: parameterised depth, 64-bit entries, push/pop/flush, full/empty/count.

Verification
REQ-035 Reset release, memory latency 1, out_ready = 1 -> requests issued at 0x0, 0x4, 0x8; out_pc sequence 0x0, 0x4, 0x8 with matching instructions, no gaps in steady state.
REQ-036 out_ready = 0 for 10 cycles -> FIFO holds 2 entries, imem_req_valid = 0, no entry lost when out_ready returns to 1.
REQ-037 Redirect to 0x103 while 2 requests are outstanding -> next request address is 0x100; both old responses dropped; first out_pc is 0x100.
REQ-038 imem_req_ready toggling at random, memory latency 3 -> out_pc stream strictly +4, in-flight count never exceeds 2.
REQ-039 PC at 0xFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-040 rst asserted with 1 request outstanding -> out_valid = 0 the next cycle; after release the first request is at RESET_PC and the stale response is not output.
